// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner with frame debouncer and one-hot key commit
// Rows are driven one at a time; columns are sampled at the end of each dwell.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [15:0] keyin,
  output logic        key_valid,
  output logic        key_strobe,
  output logic        multi_key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);

  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_s;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [3:0]    r_row_n;
  logic [15:0]   r_frame;
  logic          r_frame_done;
  logic [15:0]   r_cand;
  logic [MW-1:0] r_match;
  logic [15:0]   r_committed;
  logic [15:0]   r_keyin;
  logic          r_key_valid;
  logic          r_key_strobe;
  logic          r_multi_key;

  logic          w_dwell_last;
  logic          w_none;
  logic          w_single;
  logic [MW-1:0] w_match_next;
  logic          w_commit;

  assign w_dwell_last = (r_dwell == DWELL_LAST);
  assign w_none       = (r_frame == 16'h0000);
  assign w_single     = !w_none && ((r_frame & (r_frame - 16'd1)) == 16'h0000);

  always_comb begin
    w_match_next = MW'(1);
    if (r_frame == r_cand) begin
      w_match_next = (r_match == MATCH_MAX) ? r_match : r_match + MW'(1);
    end
  end

  // Committed frame includes multi-key patterns so a held chord does not re-commit.
  assign w_commit = r_frame_done && (w_match_next == MATCH_MAX) && (r_frame != r_committed);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_col_meta   <= 4'hF;
      r_col_s      <= 4'hF;
      r_dwell      <= '0;
      r_row        <= 2'd0;
      r_row_n      <= 4'b1110;
      r_frame      <= 16'h0000;
      r_frame_done <= 1'b0;
    end else begin
      r_col_meta   <= col_n;
      r_col_s      <= r_col_meta;
      r_frame_done <= 1'b0;
      if (w_dwell_last) begin
        r_dwell                     <= '0;
        r_frame[{r_row, 2'b00} +: 4] <= ~r_col_s;
        r_row                       <= r_row + 2'd1;
        r_row_n                     <= ~(4'b0001 << (r_row + 2'd1));
        r_frame_done                <= (r_row == 2'd3);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cand       <= 16'h0000;
      r_match      <= '0;
      r_committed  <= 16'h0000;
      r_keyin      <= 16'h0000;
      r_key_valid  <= 1'b0;
      r_key_strobe <= 1'b0;
      r_multi_key  <= 1'b0;
    end else begin
      r_key_strobe <= 1'b0;
      if (r_frame_done) begin
        r_cand  <= r_frame;
        r_match <= w_match_next;
      end
      if (w_commit) begin
        r_committed  <= r_frame;
        r_keyin      <= w_single ? r_frame : 16'h0000;
        r_key_valid  <= w_single;
        r_multi_key  <= !w_none && !w_single;
        r_key_strobe <= w_single;
      end
    end
  end

  assign row_n      = r_row_n;
  assign keyin      = r_keyin;
  assign key_valid  = r_key_valid;
  assign key_strobe = r_key_strobe;
  assign multi_key  = r_multi_key;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - randomized bench for keypad_scan_ctrl against a frame-level model
// The keypad model pulls a column low while its row is driven and the key is held.
module tb_keypad_scan_ctrl;

  localparam int S = 4;
  localparam int D = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keyin;
  logic        key_valid;
  logic        key_strobe;
  logic        multi_key;
  logic [15:0] keys = 16'h0000;

  keypad_scan_ctrl #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .col_n      (col_n),
    .row_n      (row_n),
    .keyin      (keyin),
    .key_valid  (key_valid),
    .key_strobe (key_strobe),
    .multi_key  (multi_key)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] == 1'b0 && keys[r*4+c]) col_n[c] = 1'b0;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          t       = 0;
  int          cyc     = 0;
  bit          m_live  = 0;
  logic [15:0] hist [0:7];
  logic [15:0] m_frame, m_done, m_cand, m_comm, m_key;
  int          m_cnt;
  bit          m_pend, m_valid, m_strobe, m_multi;
  int          dut_strobes = 0;
  int          mdl_strobes = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Frame-level debounce rule: D identical frames, then commit if different from last commit.
  task automatic debounce(input logic [15:0] f);
    if (f == m_cand) begin
      if (m_cnt < D) m_cnt++;
    end else begin
      m_cand = f;
      m_cnt  = 1;
    end
    if (m_cnt == D && m_cand != m_comm) begin
      m_comm = m_cand;
      case ($countones(m_cand))
        0:       begin m_key = 16'h0; m_valid = 0; m_multi = 0; end
        1:       begin m_key = m_cand; m_valid = 1; m_multi = 0; m_strobe = 1; end
        default: begin m_key = 16'h0; m_valid = 0; m_multi = 1; end
      endcase
    end
  endtask

  task automatic step();
    bit rst_now;
    int r;
    rst_now = RST;
    t++;
    hist[t % 8] = keys;
    @(posedge CLK);
    if (rst_now) begin
      m_live = 1; cyc = 0; m_frame = 0; m_cand = 0; m_comm = 0; m_cnt = 0; m_pend = 0;
      m_key = 0; m_valid = 0; m_strobe = 0; m_multi = 0;
    end else if (m_live) begin
      cyc++;
      m_strobe = 0;
      if (m_pend) begin
        m_pend = 0;
        debounce(m_done);
      end
      if (cyc % S == 0) begin
        r = (cyc / S - 1) % 4;
        m_frame[r*4 +: 4] = hist[(t - 2) % 8][r*4 +: 4];
        if (r == 3) begin
          m_pend = 1;
          m_done = m_frame;
        end
      end
    end
    @(negedge CLK);
    if (m_live)
      chk("cycle", {row_n, keyin, key_valid, key_strobe, multi_key},
          {~(4'b0001 << ((cyc / S) % 4)), m_key, m_valid, m_strobe, m_multi});
    if (key_strobe === 1'b1) dut_strobes++;
    if (m_strobe) mdl_strobes++;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  initial begin
    int lat;
    int guard;
    logic [15:0] pick;
    int mode;

    RST = 1'b1; keys = 16'h0;
    step(); step();
    RST = 1'b0;

    dut_strobes = 0;
    hold(64);
    chk("idle_strobes", dut_strobes, 0);
    chk("idle_keyin", keyin, 16'h0);
    chk("idle_valid", key_valid, 0);

    keys = 16'h0020; dut_strobes = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (lat < 0 && key_strobe === 1'b1) lat = i + 1;
    end
    chk("k5_keyin", keyin, 16'h0020);
    chk("k5_valid", key_valid, 1);
    chk("k5_strobes", dut_strobes, 1);
    chk("k5_latency_ok", (lat >= 1 && lat <= (D + 1) * 4 * S + 3), 1);

    keys = 16'h0; dut_strobes = 0;
    hold(100);
    chk("rel_keyin", keyin, 16'h0);
    chk("rel_valid", key_valid, 0);
    chk("rel_strobes", dut_strobes, 0);
    keys = 16'h8000; dut_strobes = 0;
    hold(100);
    chk("kf_keyin", keyin, 16'h8000);
    chk("kf_strobes", dut_strobes, 1);

    dut_strobes = 0; mdl_strobes = 0;
    for (int i = 0; i < 12; i++) begin
      keys = (i % 2 == 0) ? 16'h0100 : 16'h0000;
      hold(10);
    end
    keys = 16'h0100;
    hold(100);
    chk("k7_keyin", keyin, 16'h0100);
    chk("k7_strobes", dut_strobes, mdl_strobes);

    keys = 16'h2001; dut_strobes = 0;
    hold(100);
    chk("multi_flag", multi_key, 1);
    chk("multi_keyin", keyin, 16'h0);
    chk("multi_valid", key_valid, 0);
    chk("multi_strobes", dut_strobes, 0);
    keys = 16'h2000; dut_strobes = 0;
    hold(100);
    chk("k0_keyin", keyin, 16'h2000);
    chk("k0_multi", multi_key, 0);
    chk("k0_strobes", dut_strobes, 1);

    keys = 16'h0020;
    hold(100);
    chk("pre_rst_keyin", keyin, 16'h0020);
    guard = 0;
    while (!(((cyc / S) % 4) == 2 && (cyc % S) == 1) && guard < 100) begin
      step();
      guard++;
    end
    chk("mid_row2_reached", guard < 100, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_outputs", {keyin, key_valid, key_strobe, multi_key}, 19'h0);
    chk("rst_row_n", row_n, 4'b1110);
    dut_strobes = 0;
    hold(60);
    chk("post_rst_strobes", dut_strobes, 1);
    chk("post_rst_keyin", keyin, 16'h0020);

    for (int n = 0; n < 20; n++) begin
      mode = $urandom_range(0, 3);
      pick = 16'h0;
      if (mode == 1 || mode == 2) pick[$urandom_range(0, 15)] = 1'b1;
      if (mode == 3) begin
        pick[$urandom_range(0, 7)]  = 1'b1;
        pick[$urandom_range(8, 15)] = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 8)) begin
          keys = (keys == pick) ? 16'h0 : pick;
          hold($urandom_range(1, 12));
        end
      end
      keys = pick;
      hold($urandom_range(70, 100));
      chk("rand_keyin", keyin, ($countones(pick) == 1) ? pick : 16'h0);
      chk("rand_valid", key_valid, $countones(pick) == 1);
      chk("rand_multi", multi_key, $countones(pick) > 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
